// File: rtl/mux_arb4_pkg.sv
// Shared types, constants and the round-robin pick function for the mux_arb4 lane merger.
package mux_arb4_pkg;

    localparam int unsigned DATA_W_DEFAULT = 12;
    localparam int unsigned CLASS_W        = 2;
    localparam int unsigned NUM_LANES      = 4;

    typedef logic [CLASS_W-1:0] class_t;

    // Search order is last+1, last+2, last+3, last; iterating from the lowest priority
    // upward lets the highest-priority non-empty lane overwrite the result last.
    function automatic class_t rr_pick(input class_t last, input logic [NUM_LANES-1:0] req);
        class_t idx;
        class_t win;
        win = last;
        for (int i = NUM_LANES; i >= 1; i--) begin
            idx = last + class_t'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO: power-of-two depth, naturally wrapping pointers, count one bit wider than them.
module lane_fifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mux_arb4.sv
// Four-lane round-robin merger producing a lane-tagged output stream (class_o = source lane;
// `class` is a reserved word). Define MUX_ARB4_DROP_CNT_EN to add the saturating drop_cnt output.
module mux_arb4
    import mux_arb4_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in0,
    input  logic [DATA_W-1:0]  data_in1,
    input  logic [DATA_W-1:0]  data_in2,
    input  logic [DATA_W-1:0]  data_in3,
    input  logic               valid_0,
    input  logic               valid_1,
    input  logic               valid_2,
    input  logic               valid_3,
    output logic               ready_0,
    output logic               ready_1,
    output logic               ready_2,
    output logic               ready_3,
    output logic [DATA_W-1:0]  data_out,
    output logic [CLASS_W-1:0] class_o,
`ifdef MUX_ARB4_DROP_CNT_EN
    output logic [7:0]         drop_cnt,
`endif
    output logic               valid_out
);

    logic [DATA_W-1:0]    lane_din  [NUM_LANES];
    logic [DATA_W-1:0]    lane_dout [NUM_LANES];
    logic [NUM_LANES-1:0] lane_valid;
    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_pop;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_req;
    logic                 any_req;
    class_t               winner;

    logic [DATA_W-1:0]    data_out_q, data_out_d;
    class_t               class_q, class_d;
    logic                 valid_q, valid_d;
    class_t               last_q, last_d;

    assign lane_din[0] = data_in0;
    assign lane_din[1] = data_in1;
    assign lane_din[2] = data_in2;
    assign lane_din[3] = data_in3;

    assign lane_valid = {valid_3, valid_2, valid_1, valid_0};
    assign {ready_3, ready_2, ready_1, ready_0} = ~lane_full;
    assign lane_push  = lane_valid & ~lane_full;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_i   (reset),
            .push_i  (lane_push[g]),
            .pop_i   (lane_pop[g]),
            .din_i   (lane_din[g]),
            .dout_o  (lane_dout[g]),
            .empty_o (lane_empty[g]),
            .full_o  (lane_full[g])
        );
    end

    // Only registered FIFO state feeds the arbiter, so same-edge pushes wait a cycle.
    assign lane_req = ~lane_empty;
    assign any_req  = |lane_req;
    assign winner   = rr_pick(last_q, lane_req);

    always_comb begin
        lane_pop = '0;
        if (any_req) begin
            lane_pop[winner] = 1'b1;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        class_d    = class_q;
        valid_d    = 1'b0;
        last_d     = last_q;
        if (any_req) begin
            data_out_d = lane_dout[winner];
            class_d    = winner;
            valid_d    = 1'b1;
            last_d     = winner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            class_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= class_t'(NUM_LANES - 1);
        end else begin
            data_out_q <= data_out_d;
            class_q    <= class_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign data_out  = data_out_q;
    assign class_o   = class_q;
    assign valid_out = valid_q;

`ifdef MUX_ARB4_DROP_CNT_EN
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic [NUM_LANES-1:0] lane_drop;
    logic [8:0]           drop_sum;

    assign lane_drop = lane_valid & lane_full;

    // Nine bits hold 255 + 4 without wrapping before the saturation test.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_LANES; i++) begin
            drop_sum = drop_sum + 9'(lane_drop[i]);
        end
        drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb4.sv
// Scoreboard bench for mux_arb4: stimulus queues expected {class,data}; a negedge monitor checks.
module tb_mux_arb4;

    typedef struct packed {
        logic [1:0]  cls;
        logic [11:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] din [4];
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [11:0] data_out;
    logic [1:0]  class_o;
    logic        valid_out;
`ifdef MUX_ARB4_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    item_t exp_q[$];
    item_t mon_e;
    int    checks;
    int    failures;
    int    rx_cnt [4];

    always #5 clk = ~clk;

    mux_arb4 #(
        .DATA_W (12),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in0  (din[0]),
        .data_in1  (din[1]),
        .data_in2  (din[2]),
        .data_in3  (din[3]),
        .valid_0   (vld[0]),
        .valid_1   (vld[1]),
        .valid_2   (vld[2]),
        .valid_3   (vld[3]),
        .ready_0   (rdy[0]),
        .ready_1   (rdy[1]),
        .ready_2   (rdy[2]),
        .ready_3   (rdy[3]),
        .data_out  (data_out),
        .class_o   (class_o),
`ifdef MUX_ARB4_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .valid_out (valid_out)
    );

    // Monitor: every output beat must match the oldest expected item.
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            checks++;
            rx_cnt[class_o]++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got class=%0d data=%h, required no output",
                         class_o, data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cls !== class_o || mon_e.data !== data_out) begin
                    failures++;
                    $display("FAIL out_beat: got class=%0d data=%h, required class=%0d data=%h",
                             class_o, data_out, mon_e.cls, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_item(input logic [1:0] cls, input logic [11:0] data);
        exp_q.push_back(item_t'{cls: cls, data: data});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        vld      = '0;
        for (int i = 0; i < 4; i++) begin
            din[i]    = '0;
            rx_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            check("idle_state", {rdy, valid_out, data_out, class_o}, {4'hF, 1'b0, 12'h000, 2'd0});
            tick();
        end

        // Lone word: visible exactly at the second edge after the push.
        din[2] = 12'hABC;
        vld[2] = 1'b1;
        expect_item(2'd2, 12'hABC);
        tick();
        vld[2] = 1'b0;
        check("single_not_yet", valid_out, 1'b0);
        tick();
        check("single_out", {valid_out, class_o, data_out}, {1'b1, 2'd2, 12'hABC});
        tick();
        check("single_one_beat", valid_out, 1'b0);
        drain("single_drain");

        // Round-robin from reset: one word per lane, same cycle.
        pulse_reset();
        din[0] = 12'h100;
        din[1] = 12'h201;
        din[2] = 12'h302;
        din[3] = 12'h403;
        vld    = 4'hF;
        for (int l = 0; l < 4; l++) begin
            expect_item(2'(l), din[l]);
        end
        tick();
        vld = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_back_to_back", valid_out, 1'b1);
        end
        drain("rr_drain");

        // Grant lane 1 first, then lanes 0 and 3 together: lane 3 precedes lane 0.
        din[1] = 12'h511;
        vld[1] = 1'b1;
        expect_item(2'd1, 12'h511);
        tick();
        vld[1] = 1'b0;
        tick();
        din[0] = 12'h620;
        din[3] = 12'h633;
        vld    = 4'b1001;
        expect_item(2'd3, 12'h633);
        expect_item(2'd0, 12'h620);
        tick();
        vld = '0;
        drain("fair_drain");

        // Make lane 1 the last-served lane, then overfill it while 2, 3, 0 win first.
        din[1] = 12'h711;
        vld[1] = 1'b1;
        expect_item(2'd1, 12'h711);
        tick();
        vld[1] = 1'b0;
        tick();
        din[0] = 12'hC00;
        din[2] = 12'hC22;
        din[3] = 12'hC33;
        din[1] = 12'h801;
        vld    = 4'hF;
        expect_item(2'd2, 12'hC22);
        expect_item(2'd3, 12'hC33);
        expect_item(2'd0, 12'hC00);
        for (int k = 1; k <= 4; k++) begin
            expect_item(2'd1, 12'(12'h800 + k));
        end
        tick();
        vld    = 4'b0010;
        din[1] = 12'h802;
        check("full_ready_1word", rdy[1], 1'b1);
        tick();
        din[1] = 12'h803;
        tick();
        din[1] = 12'h804;
        check("full_ready_3words", rdy[1], 1'b1);
        tick();
        check("full_ready_low", rdy[1], 1'b0);
        din[1] = 12'h805;
        tick();
        vld = '0;
        check("full_ready_freed", rdy[1], 1'b1);
`ifdef MUX_ARB4_DROP_CNT_EN
        check("drop_cnt_one", drop_cnt, 8'd1);
`endif
        drain("full_drain");

        // Reset mid-stream with a word still queued on lane 0.
        din[0] = 12'h901;
        vld[0] = 1'b1;
        expect_item(2'd0, 12'h901);
        expect_item(2'd0, 12'h902);
        tick();
        din[0] = 12'h902;
        tick();
        din[0] = 12'h903;
        tick();
        vld[0] = 1'b0;
        check("midrst_pre_valid", valid_out, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_async_valid", valid_out, 1'b0);
        check("midrst_ready", rdy, 4'hF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) tick();
        check("midrst_no_stale", exp_q.size(), 0);
        drain("midrst_drain");

        // Loopback: per-lane demux of the output must reproduce each lane's sequence.
        for (int l = 0; l < 4; l++) begin
            rx_cnt[l] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 4; l++) begin
                din[l] = 12'(12'hA00 + l * 16 + k);
                expect_item(2'(l), din[l]);
            end
            vld = 4'hF;
            tick();
        end
        vld = '0;
        drain("loop_drain");
        for (int l = 0; l < 4; l++) begin
            check("loop_lane_count", rx_cnt[l], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
